layer_seq_ctrl: RTL and testbench

//   Parametrised layer sequencer for the CNN accelerator top level. Steps through NUM_LAYERS layers.
//   Per-layer post-processing enables (ReLU, pooling) come from parameter masks.

---
 rtl/layer_seq_ctrl.sv | 150 +++++++++++++++
 tb/tb_layer_seq_ctrl.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: walks NUM_LAYERS layers with a start/done pulse handshake,
// profiles RUN cycles per layer and per run, and traps timeouts and aborts in ERR.
module layer_seq_ctrl #(
  parameter int                    NUM_LAYERS = 5,
  parameter int                    IDX_W      = 3,
  parameter logic [NUM_LAYERS-1:0] RELU_MASK  = 5'b01111,
  parameter logic [NUM_LAYERS-1:0] POOL_MASK  = 5'b00011,
  parameter int                    CYC_W      = 24,
  parameter int                    TIMEOUT    = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             compute_start,
  input  logic             layer_done,
  input  logic             abort,
  input  logic             clear,
  output logic [2:0]       phase,
  output logic [IDX_W-1:0] layer_idx,
  output logic             layer_start,
  output logic             is_ReLU,
  output logic             is_Pooling,
  output logic             busy,
  output logic             compute_finish,
  output logic             timeout_err,
  output logic             err_is_abort,
  output logic [CYC_W-1:0] last_cycles,
  output logic [CYC_W-1:0] total_cycles
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } phase_t;

  // Masks are widened to the full index range so layer_idx can index them directly.
  localparam int                DEPTH     = 2 ** IDX_W;
  localparam logic [DEPTH-1:0]  RELU_EXT  = DEPTH'(RELU_MASK);
  localparam logic [DEPTH-1:0]  POOL_EXT  = DEPTH'(POOL_MASK);
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(NUM_LAYERS - 1);
  localparam logic [CYC_W-1:0]  TIMEOUT_C = CYC_W'(TIMEOUT);

  phase_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [CYC_W-1:0] last_q, last_d;
  logic [CYC_W-1:0] total_q, total_d;
  logic             abt_q, abt_d;
  logic [CYC_W-1:0] cyc_inc;
  logic [CYC_W-1:0] total_inc;

  assign cyc_inc   = (cyc_q == '1)   ? cyc_q   : cyc_q + 1'b1;
  assign total_inc = (total_q == '1) ? total_q : total_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cyc_q   <= '0;
      last_q  <= '0;
      total_q <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cyc_q   <= cyc_d;
      last_q  <= last_d;
      total_q <= total_d;
      abt_q   <= abt_d;
    end
  end

  // Handshake: layer_start is a one-cycle pulse (the START phase); the address
  // controller answers with a one-cycle layer_done pulse, honoured only in RUN.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cyc_d   = cyc_q;
    last_d  = last_q;
    total_d = total_q;
    abt_d   = abt_q;
    case (state_q)
      IDLE: begin
        if (compute_start) begin
          state_d = START;
          idx_d   = '0;
          cyc_d   = '0;
          total_d = '0;
          abt_d   = 1'b0;
        end
      end
      START: begin
        if (abort) begin
          state_d = ERR;
          abt_d   = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        cyc_d   = cyc_inc;
        total_d = total_inc;
        if (abort) begin
          state_d = ERR;
          abt_d   = 1'b1;
        end else if (layer_done) begin
          last_d = cyc_inc;
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            cyc_d   = '0;
            state_d = START;
          end
        end else if ((TIMEOUT != 0) && (cyc_inc == TIMEOUT_C)) begin
          state_d = ERR;
          abt_d   = 1'b0;
        end
      end
      DONE, ERR: begin
        if (clear) begin
          state_d = IDLE;
        end else if (compute_start) begin
          state_d = START;
          idx_d   = '0;
          cyc_d   = '0;
          last_d  = '0;
          total_d = '0;
          abt_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign phase          = state_q;
  assign layer_idx      = idx_q;
  assign busy           = (state_q == START) || (state_q == RUN);
  assign layer_start    = (state_q == START);
  assign is_ReLU        = busy && RELU_EXT[idx_q];
  assign is_Pooling     = busy && POOL_EXT[idx_q];
  assign compute_finish = (state_q == DONE);
  assign timeout_err    = (state_q == ERR);
  assign err_is_abort   = (state_q == ERR) && abt_q;
  assign last_cycles    = last_q;
  assign total_cycles   = total_q;

endmodule

// File: tb/tb_layer_seq_ctrl.sv
// Bench for layer_seq_ctrl: three instances (defaults, TIMEOUT=8, single layer);
// every phase change is checked against a queued snapshot of all outputs.
module tb_layer_seq_ctrl;

  localparam int SW = 61;
  localparam int QW = 63;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cs[3], ld[3], ab[3], cl[3];
  logic [2:0]  ph[3], ix[3];
  logic        ls[3], relu[3], pool[3], busy[3], fin[3], terr[3], abt[3];
  logic [23:0] last[3], tot[3];

  layer_seq_ctrl u_dflt (
    .clk(clk), .rst_n(rst_n), .compute_start(cs[0]), .layer_done(ld[0]), .abort(ab[0]),
    .clear(cl[0]), .phase(ph[0]), .layer_idx(ix[0]), .layer_start(ls[0]), .is_ReLU(relu[0]),
    .is_Pooling(pool[0]), .busy(busy[0]), .compute_finish(fin[0]), .timeout_err(terr[0]),
    .err_is_abort(abt[0]), .last_cycles(last[0]), .total_cycles(tot[0]));

  layer_seq_ctrl #(.TIMEOUT(8)) u_tmo (
    .clk(clk), .rst_n(rst_n), .compute_start(cs[1]), .layer_done(ld[1]), .abort(ab[1]),
    .clear(cl[1]), .phase(ph[1]), .layer_idx(ix[1]), .layer_start(ls[1]), .is_ReLU(relu[1]),
    .is_Pooling(pool[1]), .busy(busy[1]), .compute_finish(fin[1]), .timeout_err(terr[1]),
    .err_is_abort(abt[1]), .last_cycles(last[1]), .total_cycles(tot[1]));

  layer_seq_ctrl #(.NUM_LAYERS(1), .RELU_MASK(1'b1), .POOL_MASK(1'b0)) u_one (
    .clk(clk), .rst_n(rst_n), .compute_start(cs[2]), .layer_done(ld[2]), .abort(ab[2]),
    .clear(cl[2]), .phase(ph[2]), .layer_idx(ix[2]), .layer_start(ls[2]), .is_ReLU(relu[2]),
    .is_Pooling(pool[2]), .busy(busy[2]), .compute_finish(fin[2]), .timeout_err(terr[2]),
    .err_is_abort(abt[2]), .last_cycles(last[2]), .total_cycles(tot[2]));

  int checks = 0;
  int errors = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] mon_e;
  logic [2:0]    ph_prev[3];
  logic          mon_en = 1'b0;

  function automatic logic [SW-1:0] get_snap(input int k);
    return {ph[k], ix[k], ls[k], relu[k], pool[k], busy[k], fin[k], terr[k], abt[k], last[k], tot[k]};
  endfunction

  function automatic logic [SW-1:0] mk(input int p, input int idx, input bit s, input bit r,
                                        input bit pl, input bit b, input bit f, input bit t,
                                        input bit a, input int lc, input int tc);
    return {3'(p), 3'(idx), s, r, pl, b, f, t, a, 24'(lc), 24'(tc)};
  endfunction

  task automatic push(input int k, input logic [SW-1:0] s);
    exp_q.push_back({2'(k), s});
  endtask

  // Shorthands for the common snapshots: START, RUN, ERR and IDLE.
  task automatic exp_start(input int k, input int idx, input bit r, input bit pl, input int lc, input int tc);
    push(k, mk(1, idx, 1, r, pl, 1, 0, 0, 0, lc, tc));
  endtask
  task automatic exp_run(input int k, input int idx, input bit r, input bit pl, input int lc, input int tc);
    push(k, mk(2, idx, 0, r, pl, 1, 0, 0, 0, lc, tc));
  endtask
  task automatic exp_err(input int k, input int idx, input bit a, input int lc, input int tc);
    push(k, mk(4, idx, 0, 0, 0, 0, 0, 1, a, lc, tc));
  endtask
  task automatic exp_idle(input int k, input int idx, input int lc, input int tc);
    push(k, mk(0, idx, 0, 0, 0, 0, 0, 0, 0, lc, tc));
  endtask

  task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int k, input logic c, input logic l, input logic a, input logic r);
    cs[k] = c; ld[k] = l; ab[k] = a; cl[k] = r;
    tick();
    cs[k] = 1'b0; ld[k] = 1'b0; ab[k] = 1'b0; cl[k] = 1'b0;
  endtask

  // Called while in START: n RUN cycles elapse, layer_done is high in the last one.
  task automatic run_layer(input int k, input int n);
    repeat (n) tick();
    drive(k, 0, 1, 0, 0);
  endtask

  // Scoreboard monitor: any phase change on any instance pops one expected snapshot.
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (mon_en && (ph[k] != ph_prev[k])) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_phase_change: dut %0d got %h expected none", k, get_snap(k));
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e !== {2'(k), get_snap(k)}) begin
            errors++;
            $display("FAIL phase_snapshot: got %h expected %h", {2'(k), get_snap(k)}, mon_e);
          end
        end
      end
      ph_prev[k] = ph[k];
    end
  end

  int relu_t[5] = '{1, 1, 1, 1, 0};
  int pool_t[5] = '{1, 1, 0, 0, 0};
  int wait_n;

  initial begin
    for (int k = 0; k < 3; k++) begin
      cs[k] = 1'b0; ld[k] = 1'b0; ab[k] = 1'b0; cl[k] = 1'b0; ph_prev[k] = 3'd0;
    end
    repeat (3) tick();
    rst_n = 1'b1;
    check("reset_dflt", get_snap(0), '0);
    check("reset_tmo",  get_snap(1), '0);
    check("reset_one",  get_snap(2), '0);
    mon_en = 1'b1;

    // T1: full default run, 3 RUN cycles per layer.
    for (int i = 0; i < 5; i++) begin
      exp_start(0, i, relu_t[i] != 0, pool_t[i] != 0, (i == 0) ? 0 : 3, 3 * i);
      exp_run(0, i, relu_t[i] != 0, pool_t[i] != 0, (i == 0) ? 0 : 3, 3 * i);
    end
    push(0, mk(3, 4, 0, 0, 0, 0, 1, 0, 0, 3, 15));
    drive(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) run_layer(0, 3);
    tick();

    // T5: restart from DONE, then synchronous reset mid-RUN.
    exp_start(0, 0, 1, 1, 0, 0);
    exp_run(0, 0, 1, 1, 0, 0);
    exp_idle(0, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // T3: abort in the first RUN cycle of layer 1, then clear.
    exp_start(0, 0, 1, 1, 0, 0);
    exp_run(0, 0, 1, 1, 0, 0);
    exp_start(0, 1, 1, 1, 3, 3);
    exp_run(0, 1, 1, 1, 3, 3);
    exp_err(0, 1, 1, 3, 4);
    exp_idle(0, 1, 3, 4);
    drive(0, 1, 0, 0, 0);
    run_layer(0, 3);
    tick();
    drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    tick();

    // T2: TIMEOUT=8, layer 2 never finishes.
    exp_start(1, 0, 1, 1, 0, 0);
    exp_run(1, 0, 1, 1, 0, 0);
    exp_start(1, 1, 1, 1, 3, 3);
    exp_run(1, 1, 1, 1, 3, 3);
    exp_start(1, 2, 1, 0, 3, 6);
    exp_run(1, 2, 1, 0, 3, 6);
    exp_err(1, 2, 0, 3, 14);
    drive(1, 1, 0, 0, 0);
    run_layer(1, 3);
    run_layer(1, 3);
    wait_n = 0;
    while (ph[1] != 3'd4 && wait_n < 30) begin
      tick();
      wait_n++;
    end
    if (ph[1] != 3'd4) begin
      checks++;
      errors++;
      $display("FAIL t2_timeout_wait: got phase %0d expected 4", ph[1]);
    end

    // T4: restart from ERR; layer_done on the 8th RUN cycle beats the timeout.
    exp_start(1, 0, 1, 1, 0, 0);
    exp_run(1, 0, 1, 1, 0, 0);
    exp_start(1, 1, 1, 1, 8, 8);
    exp_err(1, 1, 1, 8, 8);
    exp_idle(1, 1, 8, 8);
    drive(1, 1, 0, 0, 0);
    run_layer(1, 8);
    drive(1, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 1);
    tick();

    // T6: single layer; layer_done during START is ignored; clear beats compute_start.
    exp_start(2, 0, 1, 0, 0, 0);
    exp_run(2, 0, 1, 0, 0, 0);
    push(2, mk(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1));
    exp_idle(2, 0, 1, 1);
    drive(2, 1, 0, 0, 0);
    drive(2, 0, 1, 0, 0);
    drive(2, 0, 1, 0, 0);
    drive(2, 1, 0, 0, 1);
    repeat (3) tick();

    check("queue_drained", SW'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
